data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 130 +++++++++++++
 tb/tb_data_memory.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
//   Line-oriented backing memory for a cache. A request (read or write of a
//   whole 256-bit line) is captured from IDLE, held for a fixed number of
//   cycles in BUSY, and completed with a one-cycle ack. The array itself is
//   single-ported and written/read only on the BUSY->ACK edge.
//
// Parameters
//   LATENCY  cycles from request capture to ack (2..255)
//   DEPTH    number of 256-bit lines (power of two)
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset (array contents are kept)
//   enable_i  request valid, sampled only in IDLE
//   write_i   1 = line write, 0 = line read, sampled with enable_i
//   addr_i    byte address; [4:0] ignored, bits above the index alias
//   data_i    write line data, sampled with enable_i
//   ack_o     registered one-cycle completion pulse
//   data_o    registered read data, held until the next read completes
// ----------------------------------------------------------------------------
module data_memory #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  CNT_LAST = 8'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [255:0]       wdata_q, wdata_d;
  logic               ack_q, ack_d;
  logic [255:0]       data_q;

  logic [255:0]       mem_q [DEPTH];

  // Offset bits and the aliased upper address bits are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{addr_i[4:0], (addr_i >> (5 + IDX_W))};

  // The single array access happens on the edge that moves BUSY -> ACK.
  // state_q is cleared asynchronously, so a reset during BUSY suppresses it.
  logic access;
  assign access = (state_q == BUSY) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          write_d = write_i;
          idx_d   = addr_i[5 +: IDX_W];
          wdata_d = data_i;
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (access) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  // Registered read port; only a completing read updates the output.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
    end else if (access && !write_q) begin
      data_q <= mem_q[idx_q];
    end
  end

  // Array write port; no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (access && write_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int LAT   = 10;
  localparam int DEPTH = 512;

  logic         clk_i    = 1'b0;
  logic         rst_i    = 1'b0;
  logic         enable_i = 1'b0;
  logic         write_i  = 1'b0;
  logic [31:0]  addr_i   = '0;
  logic [255:0] data_i   = '0;
  logic         ack_o;
  logic [255:0] data_o;

  always #5 clk_i = ~clk_i;

  data_memory #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  longint cyc    = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    bit           w;
    int unsigned  idx;
    logic [255:0] d;
    longint       exp_cyc;
  } txn_t;

  txn_t         sb[$];
  txn_t         mt;
  logic [255:0] model_mem [DEPTH];
  bit           known [DEPTH];
  logic [255:0] exp_data = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 32) % DEPTH;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: pops the scoreboard on each ack and keeps the expected data_o.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (ack_o) begin
        if (sb.size() == 0) begin
          chk("spurious_ack", 256'(ack_o), 256'd0);
        end else begin
          mt = sb.pop_front();
          chk("ack_cycle", 256'(cyc), 256'(mt.exp_cyc));
          if (mt.w) begin
            model_mem[mt.idx] = mt.d;
            known[mt.idx]     = 1'b1;
          end else begin
            exp_data = model_mem[mt.idx];
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
        chk("missing_ack", 256'(ack_o), 256'd1);
        void'(sb.pop_front());
      end
      chk("data_o", data_o, exp_data);
    end
  end

  task automatic wait_ack();
    int k = 0;
    do begin
      @(posedge clk_i); #1;
      k++;
    end while (!ack_o && k < LAT + 5);
    if (!ack_o) chk("ack_timeout", 256'(ack_o), 256'd1);
  endtask

  // Issue one request from IDLE, hold it until ack, then release.
  task automatic req(input bit w, input logic [31:0] a, input logic [255:0] d);
    enable_i = 1'b1; write_i = w; addr_i = a; data_i = d;
    sb.push_back('{w, line_of(a), d, cyc + LAT});
    wait_ack();
    enable_i = 1'b0; write_i = 1'($urandom); addr_i = $urandom; data_i = rand_line();
    @(posedge clk_i); #1;
  endtask

  logic [255:0] line_a, line_b, line_c, line_e;
  longint       ack1, ack2;

  initial begin
    // Reset state
    #12;
    chk("reset_ack", 256'(ack_o), 256'd0);
    chk("reset_data", data_o, 256'd0);
    #10 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Basic write, then read back with idle cycles after
    req(1'b1, 32'h0000_0420, {8{32'hDEADBEEF}});
    req(1'b0, 32'h0000_0420, '0);
    repeat (5) @(posedge clk_i);
    #1;

    // Writeback then refill with enable held high across the ack
    line_a = rand_line();
    line_b = rand_line();
    req(1'b1, 32'h0000_0800, line_b);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0400; data_i = line_a;
    sb.push_back('{1'b1, line_of(32'h400), line_a, cyc + LAT});
    wait_ack();
    ack1 = cyc;
    write_i = 1'b0; addr_i = 32'h0000_0800; data_i = rand_line();
    sb.push_back('{1'b0, line_of(32'h800), '0, cyc + LAT + 1});
    wait_ack();
    ack2 = cyc;
    chk("b2b_spacing", 256'(ack2 - ack1), 256'(LAT + 1));
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    req(1'b0, 32'h0000_0400, '0);

    // Input churn during BUSY
    req(1'b1, 32'h0000_0020, rand_line());
    req(1'b1, 32'h0000_0040, rand_line());
    enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0020;
    sb.push_back('{1'b0, line_of(32'h20), '0, cyc + LAT});
    @(posedge clk_i); #1;
    for (int i = 0; i < LAT - 1; i++) begin
      enable_i = 1'($urandom);
      write_i  = 1'($urandom);
      case ($urandom_range(0, 3))
        0: addr_i = 32'h0000_0020;
        1: addr_i = 32'h0000_0040;
        2: addr_i = 32'h0000_0420;
        default: addr_i = $urandom;
      endcase
      data_i = rand_line();
      @(posedge clk_i); #1;
    end
    chk("churn_ack", 256'(ack_o), 256'd1);
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    req(1'b0, 32'h0000_0040, '0);
    req(1'b0, 32'h0000_0420, '0);
    req(1'b0, 32'h0000_0020, '0);

    // Reset in the middle of a write
    line_c = rand_line();
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0040; data_i = line_c;
    @(posedge clk_i); #1;
    repeat (5) @(posedge clk_i);
    #2;
    exp_data = '0;
    rst_i    = 1'b0;
    enable_i = 1'b0;
    #1;
    chk("rst_async_ack", 256'(ack_o), 256'd0);
    chk("rst_async_data", data_o, 256'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (LAT + 3) @(posedge clk_i);
    #1;
    req(1'b0, 32'h0000_0040, '0);

    // Aliasing and last index, offset bits set on the read
    line_e = rand_line();
    req(1'b1, 32'h0000_3FE0, line_e);
    req(1'b0, 32'h0000_7FFF, '0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit           w;
      logic [31:0]  a;
      w = 1'($urandom);
      a = $urandom;
      if (!w && !known[line_of(a)]) w = 1'b1;
      req(w, a, rand_line());
    end

    repeat (5) @(posedge clk_i);
    #1;
    chk("scoreboard_empty", 256'(sb.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
